secuenciador_barrido_rtc: RTL



---
 rtl/secuenciador_barrido_rtc.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/secuenciador_barrido_rtc.sv
// secuenciador_barrido_rtc: periodic sweep of nine RTC registers into the VGA bank
// plus PicoBlaze write arbitration; RTC_TRANSFER_CMD_EN prepends a transfer command.
module secuenciador_barrido_rtc #(
  parameter int unsigned PERIOD_CYCLES  = 5_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [7:0]  ADDR_SEG_H     = 8'h21,
  parameter logic [7:0]  ADDR_MIN_H     = 8'h22,
  parameter logic [7:0]  ADDR_HORA_H    = 8'h23,
  parameter logic [7:0]  ADDR_DIA_F     = 8'h24,
  parameter logic [7:0]  ADDR_MES_F     = 8'h25,
  parameter logic [7:0]  ADDR_JAHR_F    = 8'h26,
  parameter logic [7:0]  ADDR_SEG_T     = 8'h41,
  parameter logic [7:0]  ADDR_MIN_T     = 8'h42,
  parameter logic [7:0]  ADDR_HORA_T    = 8'h43,
  parameter logic [7:0]  CMD_ADDR       = 8'hF0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       fin_lectura_escritura,
  input  logic [7:0] out_dato,
  output logic       en_funcion,
  output logic       escribir_leer,
  output logic [7:0] addr_RAM,
  output logic [7:0] in_dato,
  output logic [7:0] data_out,
  output logic [8:0] load_reg,
  output logic       busy,
  output logic       wr_done,
  output logic       timeout_err
);

  typedef enum logic [3:0] {
    IDLE, SETUP, ACCESS, LOAD, NEXT, WR_SETUP, WR_ACCESS
`ifdef RTC_TRANSFER_CMD_EN
    , CMD_SET, CMD_WAIT
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [23:0] pcnt;
  logic [9:0]  tcnt;
  logic        tick, tick_pend, wr_pend;
  logic [7:0]  wr_addr_q, wr_data_q, wa, wd;
  logic        tick_any, wr_any, in_acc, tmo;
  logic        sweep_go, wr_go;

  function automatic logic [7:0] addr_of(input logic [3:0] i);
    case (i)
      4'd0:    addr_of = ADDR_SEG_H;
      4'd1:    addr_of = ADDR_MIN_H;
      4'd2:    addr_of = ADDR_HORA_H;
      4'd3:    addr_of = ADDR_DIA_F;
      4'd4:    addr_of = ADDR_MES_F;
      4'd5:    addr_of = ADDR_JAHR_F;
      4'd6:    addr_of = ADDR_SEG_T;
      4'd7:    addr_of = ADDR_MIN_T;
      default: addr_of = ADDR_HORA_T;
    endcase
  endfunction

  assign tick     = enable && (pcnt == 24'(PERIOD_CYCLES - 1));
  assign tick_any = tick | tick_pend;
  assign wr_any   = wr_req | wr_pend;
  assign wr_go    = (state == IDLE) && wr_any;
  assign sweep_go = (state == IDLE) && !wr_any && tick_any;
  // A request arriving in the same cycle it is consumed wins over the latch
  assign wa       = wr_req ? wr_addr : wr_addr_q;
  assign wd       = wr_req ? wr_data : wr_data_q;

`ifdef RTC_TRANSFER_CMD_EN
  assign in_acc = (state == ACCESS) || (state == WR_ACCESS) ||
                  (state == CMD_WAIT);
`else
  assign in_acc = (state == ACCESS) || (state == WR_ACCESS);
`endif

  assign tmo = in_acc && !fin_lectura_escritura &&
               (tcnt == 10'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      IDLE: begin
        if (wr_any) begin
          state_nxt = WR_SETUP;
        end else if (tick_any) begin
          idx_nxt   = 4'd0;
`ifdef RTC_TRANSFER_CMD_EN
          state_nxt = CMD_SET;
`else
          state_nxt = SETUP;
`endif
        end
      end
`ifdef RTC_TRANSFER_CMD_EN
      CMD_SET:  state_nxt = CMD_WAIT;
      CMD_WAIT: if (fin_lectura_escritura || tmo) state_nxt = SETUP;
`endif
      SETUP:    state_nxt = ACCESS;
      ACCESS: begin
        if (fin_lectura_escritura) state_nxt = LOAD;
        else if (tmo)              state_nxt = NEXT;
      end
      LOAD:     state_nxt = NEXT;
      NEXT: begin
        if (idx == 4'd8) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt   = idx + 4'd1;
          state_nxt = SETUP;
        end
      end
      WR_SETUP:  state_nxt = WR_ACCESS;
      WR_ACCESS: if (fin_lectura_escritura || tmo) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    en_funcion = in_acc;
    busy       = (state != IDLE);
    load_reg   = 9'h000;
    if (state == LOAD) load_reg[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= 4'd0;
      pcnt          <= 24'd0;
      tcnt          <= 10'd0;
      tick_pend     <= 1'b0;
      wr_pend       <= 1'b0;
      wr_addr_q     <= 8'h00;
      wr_data_q     <= 8'h00;
      addr_RAM      <= 8'h00;
      in_dato       <= 8'h00;
      escribir_leer <= 1'b0;
      data_out      <= 8'h00;
      wr_done       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      idx  <= idx_nxt;
      if (enable) pcnt <= tick ? 24'd0 : pcnt + 24'd1;
      tcnt      <= in_acc ? tcnt + 10'd1 : 10'd0;
      tick_pend <= sweep_go ? 1'b0 : (tick_pend | tick);
      wr_pend   <= wr_go ? 1'b0 : (wr_pend | wr_req);
      if (wr_req) begin
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
      end
      // Bus fields are loaded on entry to the setup cycle, ahead of en_funcion
      if (state_nxt == SETUP) begin
        addr_RAM      <= addr_of(idx_nxt);
        escribir_leer <= 1'b0;
      end else if (state_nxt == WR_SETUP) begin
        addr_RAM      <= wa;
        in_dato       <= wd;
        escribir_leer <= 1'b1;
      end
`ifdef RTC_TRANSFER_CMD_EN
      else if (state_nxt == CMD_SET) begin
        addr_RAM      <= CMD_ADDR;
        in_dato       <= 8'h00;
        escribir_leer <= 1'b1;
      end
`endif
      if (state == ACCESS && fin_lectura_escritura) data_out <= out_dato;
      wr_done <= (state == WR_ACCESS) && fin_lectura_escritura;
      if (sweep_go) timeout_err <= 1'b0;
      else if (tmo) timeout_err <= 1'b1;
    end
  end

endmodule
